// File: rtl/fetch_tlb_refill_controller_pkg.sv
// -----------------------------------------------------------------------------
// Rv32Types
// Shared RV32 / Sv32 translation types used by the fetch TLB refill walker.
//   paddr_t   : 34-bit physical address
//   vpn_t     : 20-bit virtual page number (vpn1 = [19:10], vpn0 = [9:0])
//   ppn_t     : 22-bit physical page number
//   pte_t     : Sv32 page-table entry, {ppn, rsw, D, A, G, U, X, W, R, V}
//   pte_addr  : address of the PTE selected by a VPN segment in a table page
// -----------------------------------------------------------------------------
package Rv32Types;

    localparam int XLEN       = 32;
    localparam int VPN_W      = 20;
    localparam int VPN_SEG_W  = 10;
    localparam int PPN_W      = 22;
    localparam int PADDR_W    = 34;
    localparam int FLAGS_W    = 8;

    typedef logic [PADDR_W-1:0]   paddr_t;
    typedef logic [VPN_W-1:0]     vpn_t;
    typedef logic [VPN_SEG_W-1:0] vpn_seg_t;
    typedef logic [PPN_W-1:0]     ppn_t;

    typedef struct packed {
        ppn_t       ppn;
        logic [1:0] rsw;
        logic       d;
        logic       a;
        logic       g;
        logic       u;
        logic       x;
        logic       w;
        logic       r;
        logic       v;
    } pte_t;

    // Table page base plus 4-byte PTE index; plain 34-bit unsigned add.
    function automatic paddr_t pte_addr(input ppn_t base, input vpn_seg_t idx);
        return {base, 12'b0} + {22'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_tlb_refill_controller_if.sv
// -----------------------------------------------------------------------------
// fetch_tlb_refill_controller_if
// Page-table read port between the refill walker and the memory system.
//   memReq       : walker -> memory, read request
//   memAddr      : walker -> memory, physical PTE address
//   memGrant     : memory -> walker, request accepted this cycle
//   memReadValid : memory -> walker, read data valid this cycle
//   memReadData  : memory -> walker, raw 32-bit PTE
//
// Handshake: once memReq rises, memReq and memAddr hold steady until the cycle
// in which memGrant is sampled high; that cycle transfers the request. Exactly
// one memReadValid pulse follows each granted request, in a later cycle.
// -----------------------------------------------------------------------------
interface fetch_tlb_refill_controller_if;
    import Rv32Types::*;

    logic        memReq;
    paddr_t      memAddr;
    logic        memGrant;
    logic        memReadValid;
    logic [31:0] memReadData;

    modport master (
        output memReq,
        output memAddr,
        input  memGrant,
        input  memReadValid,
        input  memReadData
    );

    modport slave (
        input  memReq,
        input  memAddr,
        output memGrant,
        output memReadValid,
        output memReadData
    );

endinterface

// File: rtl/fetch_pte_checker.sv
// -----------------------------------------------------------------------------
// fetch_pte_checker
// Combinational classification of a PTE returned during an instruction-fetch
// page walk.
//   pte_i          : PTE under test
//   level1_i       : 1 = PTE came from the root (level-1) table
//   walk_fault_o   : walk must end in a page fault
//   walk_done_o    : PTE is a usable executable leaf; walk completes
// Neither output high means a pointer to the next-level table.
// -----------------------------------------------------------------------------
module fetch_pte_checker
    import Rv32Types::*;
(
    input  pte_t pte_i,
    input  logic level1_i,
    output logic walk_fault_o,
    output logic walk_done_o
);

    logic invalid;
    logic leaf;
    logic misaligned;
    logic perm_fail;
    logic unused_bits;

    always_comb begin
        // W without R is a reserved encoding and is treated like V=0.
        invalid      = !pte_i.v || (!pte_i.r && pte_i.w);
        leaf         = pte_i.r || pte_i.x;
        // A superpage must be 4 MiB aligned in physical space.
        misaligned   = level1_i && (pte_i.ppn[9:0] != '0);
        // Fetch needs execute permission; A is never set by hardware here.
        perm_fail    = !pte_i.x || !pte_i.a;

        walk_fault_o = invalid
                    || (leaf && (misaligned || perm_fail))
                    || (!leaf && !level1_i);
        walk_done_o  = !invalid && leaf && !misaligned && !perm_fail;
    end

    assign unused_bits = ^{pte_i.rsw, pte_i.d, pte_i.g, pte_i.u};

endmodule

// File: rtl/fetch_tlb_refill_controller.sv
// -----------------------------------------------------------------------------
// fetch_tlb_refill_controller
// Sv32 two-level hardware page walker that refills the fetch TLB on a miss.
//   clk, rst          : clock, synchronous active-high reset
//   missValid/Vaddr   : fetch TLB miss report and faulting virtual PC
//   satpMode/satpPpn  : translation enable and root table PPN
//   flush             : pipeline flush, abandons the walk
//   mem               : page-table read port (master side)
//   refill*           : TLB entry written while refillEnable pulses
//   done / fault      : one-cycle walk outcome pulses
//   busy              : walker not idle
//   dbgState          : FSM state, encoded IDLE=0, L1_REQ=1, L1_WAIT=2,
//                       L0_REQ=3, L0_WAIT=4, DRAIN=5, DONE=6, FAULT=7
// -----------------------------------------------------------------------------
module fetch_tlb_refill_controller
    import Rv32Types::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 missValid,
    input  logic [XLEN-1:0]                      missVaddr,
    input  logic                                 satpMode,
    input  ppn_t                                 satpPpn,
    input  logic                                 flush,
    fetch_tlb_refill_controller_if.master        mem,
    output logic                                 refillEnable,
    output vpn_t                                 refillVpn,
    output ppn_t                                 refillPpn,
    output logic [FLAGS_W-1:0]                   refillFlags,
    output logic                                 refillSuperpage,
    output logic                                 done,
    output logic                                 fault,
    output logic                                 busy,
    output logic [2:0]                           dbgState
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L0_REQ  = 3'd3,
        L0_WAIT = 3'd4,
        DRAIN   = 3'd5,
        DONE    = 3'd6,
        FAULT   = 3'd7
    } state_e;

    state_e              state_q, state_d;
    vpn_t                vpn_q, vpn_d;
    paddr_t              addr_q, addr_d;
    ppn_t                ref_ppn_q, ref_ppn_d;
    logic [FLAGS_W-1:0]  ref_flags_q, ref_flags_d;
    logic                ref_sp_q, ref_sp_d;

    pte_t                pte;
    logic                level1;
    logic                walk_fault;
    logic                walk_done;
    logic                unusedVaddrOfs;

    assign pte            = pte_t'(mem.memReadData);
    assign level1         = (state_q == L1_WAIT);
    assign unusedVaddrOfs = ^missVaddr[11:0];

    fetch_pte_checker u_checker (
        .pte_i        (pte),
        .level1_i     (level1),
        .walk_fault_o (walk_fault),
        .walk_done_o  (walk_done)
    );

    always_comb begin
        state_d     = state_q;
        vpn_d       = vpn_q;
        addr_d      = addr_q;
        ref_ppn_d   = ref_ppn_q;
        ref_flags_d = ref_flags_q;
        ref_sp_d    = ref_sp_q;

        unique case (state_q)
            IDLE: begin
                if (missValid && satpMode) begin
                    state_d = L1_REQ;
                    vpn_d   = missVaddr[31:12];
                    addr_d  = pte_addr(satpPpn, missVaddr[31:22]);
                end
            end
            L1_REQ, L0_REQ: begin
                // A granted request owes us a response, so a flush in the
                // grant cycle must still drain it.
                if (flush) begin
                    state_d = mem.memGrant ? DRAIN : IDLE;
                end else if (mem.memGrant) begin
                    state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end
            L1_WAIT, L0_WAIT: begin
                if (mem.memReadValid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else if (walk_fault) begin
                        state_d = FAULT;
                    end else if (walk_done) begin
                        state_d     = DONE;
                        // Superpage: low PPN bits come from vpn0 of the PC.
                        ref_ppn_d   = level1 ? {pte.ppn[21:10], vpn_q[9:0]} : pte.ppn;
                        ref_flags_d = mem.memReadData[FLAGS_W-1:0];
                        ref_sp_d    = level1;
                    end else begin
                        // Valid non-leaf at level 1: descend to level 0.
                        state_d = L0_REQ;
                        addr_d  = pte_addr(pte.ppn, vpn_q[9:0]);
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem.memReadValid) begin
                    state_d = IDLE;
                end
            end
            DONE, FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vpn_q       <= '0;
            addr_q      <= '0;
            ref_ppn_q   <= '0;
            ref_flags_q <= '0;
            ref_sp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vpn_q       <= vpn_d;
            addr_q      <= addr_d;
            ref_ppn_q   <= ref_ppn_d;
            ref_flags_q <= ref_flags_d;
            ref_sp_q    <= ref_sp_d;
        end
    end

    // Outputs decode from the registered state only.
    assign mem.memReq      = (state_q == L1_REQ) || (state_q == L0_REQ);
    assign mem.memAddr     = mem.memReq ? addr_q : '0;
    assign done            = (state_q == DONE);
    assign refillEnable    = done;
    assign fault           = (state_q == FAULT);
    assign busy            = (state_q != IDLE);
    assign refillVpn       = done ? vpn_q       : '0;
    assign refillPpn       = done ? ref_ppn_q   : '0;
    assign refillFlags     = done ? ref_flags_q : '0;
    assign refillSuperpage = done && ref_sp_q;
    assign dbgState        = state_q;

endmodule

// File: tb/tb_fetch_tlb_refill_controller.sv
`timescale 1ns/1ps
module tb_fetch_tlb_refill_controller;
    import Rv32Types::*;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_L1_WAIT = 3'd2;
    localparam logic [2:0] S_L0_WAIT = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam int         RES_W     = 54;

    // Fault table: level-1 PTE, level-0 PTE (used when level 1 points down).
    localparam logic [31:0] F_L1 [6] = '{32'h0000_0000, 32'h0010_0009, 32'h0010_0449,
                                         32'h0010_0045, 32'h0000_8001, 32'h0000_8001};
    localparam logic [31:0] F_L0 [6] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                         32'h048D_1401, 32'h048D_1443};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        missValid, satpMode, flush;
    logic [31:0] missVaddr;
    ppn_t        satpPpn;
    logic        refillEnable, refillSuperpage, done, fault, busy;
    vpn_t        refillVpn;
    ppn_t        refillPpn;
    logic [7:0]  refillFlags;
    logic [2:0]  dbgState;

    fetch_tlb_refill_controller_if mem_if ();

    fetch_tlb_refill_controller dut (
        .clk             (clk),
        .rst             (rst),
        .missValid       (missValid),
        .missVaddr       (missVaddr),
        .satpMode        (satpMode),
        .satpPpn         (satpPpn),
        .flush           (flush),
        .mem             (mem_if),
        .refillEnable    (refillEnable),
        .refillVpn       (refillVpn),
        .refillPpn       (refillPpn),
        .refillFlags     (refillFlags),
        .refillSuperpage (refillSuperpage),
        .done            (done),
        .fault           (fault),
        .busy            (busy),
        .dbgState        (dbgState)
    );

    // ---------------- scoreboard state ----------------
    int                n_vec = 0;
    int                n_err = 0;
    logic [RES_W-1:0]  exp_q[$];
    paddr_t            exp_addr_q[$];
    logic [31:0]       pte_mem [paddr_t];
    int                delay_mem [paddr_t];
    int                grant_delay = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RES_W-1:0] mk_done(input vpn_t vpn, input ppn_t ppn,
                                                 input logic [7:0] flg, input logic sp);
        return {1'b0, 1'b1, 1'b1, vpn, ppn, flg, sp};
    endfunction

    function automatic logic [RES_W-1:0] mk_fault();
        return {1'b1, 1'b0, 1'b0, 51'b0};
    endfunction

    function automatic paddr_t l1_addr(input ppn_t root, input logic [31:0] va);
        return (paddr_t'(root) << 12) + paddr_t'(va[31:22]) * 4;
    endfunction

    function automatic paddr_t l0_addr(input ppn_t tbl, input logic [31:0] va);
        return (paddr_t'(tbl) << 12) + paddr_t'(va[21:12]) * 4;
    endfunction

    // ---------------- memory model ----------------
    initial begin
        logic   gnt_prev;
        logic   rd_pending;
        paddr_t gnt_addr;
        paddr_t rd_addr;
        int     rd_cnt;
        int     gnt_wait;
        gnt_prev = 0; rd_pending = 0; gnt_addr = '0; rd_addr = '0; rd_cnt = 0; gnt_wait = 0;
        mem_if.memGrant     = 1'b0;
        mem_if.memReadValid = 1'b0;
        mem_if.memReadData  = '0;
        forever begin
            @(negedge clk);
            mem_if.memReadValid = 1'b0;
            mem_if.memGrant     = 1'b0;
            if (rst) begin
                gnt_prev = 0; rd_pending = 0; gnt_wait = 0;
            end else begin
                if (gnt_prev) begin
                    rd_pending = 1;
                    rd_addr    = gnt_addr;
                    rd_cnt     = delay_mem.exists(gnt_addr) ? delay_mem[gnt_addr] : 0;
                end
                if (rd_pending) begin
                    if (rd_cnt == 0) begin
                        mem_if.memReadValid = 1'b1;
                        mem_if.memReadData  = pte_mem.exists(rd_addr) ? pte_mem[rd_addr] : 32'h0;
                        rd_pending = 0;
                    end else begin
                        rd_cnt--;
                    end
                end
                gnt_prev = 0;
                if (mem_if.memReq) begin
                    if (gnt_wait >= grant_delay) begin
                        mem_if.memGrant = 1'b1;
                        gnt_prev = 1;
                        gnt_addr = mem_if.memAddr;
                        gnt_wait = 0;
                        check("grant_expected", exp_addr_q.size() != 0, 1'b1);
                        if (exp_addr_q.size() != 0)
                            check("mem_addr", mem_if.memAddr, exp_addr_q.pop_front());
                    end else begin
                        gnt_wait++;
                    end
                end else begin
                    gnt_wait = 0;
                end
            end
        end
    end

    // ---------------- result monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (done || fault)) begin
                check("pulse_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0)
                    check("result", {fault, done, refillEnable, refillVpn, refillPpn,
                                     refillFlags, refillSuperpage}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // exp_cycle counts the missValid cycle as cycle 1; negative skips the check.
    task automatic run_miss(input logic [31:0] va, input int exp_cycle,
                            input int hold_n, input paddr_t hold_addr);
        int n;
        @(negedge clk);
        missValid = 1'b1;
        missVaddr = va;
        @(posedge clk); #1;
        missValid = 1'b0;
        n = 0;
        while (!(done || fault) && n < 100) begin
            if (n < hold_n) begin
                check("req_hold", mem_if.memReq, 1'b1);
                check("addr_hold", mem_if.memAddr, hold_addr);
            end
            @(posedge clk); #1;
            n++;
        end
        check("walk_end", done | fault, 1'b1);
        if (exp_cycle >= 0) check("latency", n + 2, exp_cycle);
        @(posedge clk); #1;
        check("pulse_len", {done, fault, refillEnable}, 3'b000);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n;
        n = 0;
        while (dbgState !== s && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, dbgState, s);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] va;
        ppn_t        root, node, leaf;
        logic [7:0]  flg;
        logic        sp;
        int          n;

        missValid = 0; missVaddr = '0; satpMode = 1; satpPpn = '0; flush = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_memreq", mem_if.memReq, 1'b0);
        check("rst_memaddr", mem_if.memAddr, 34'h0);
        check("rst_outs", {refillEnable, done, fault, busy}, 4'b0);
        check("rst_state", dbgState, S_IDLE);
        @(negedge clk);
        rst = 0;

        // 4 KiB page walk, zero-wait memory.
        satpPpn = 22'h00010;
        pte_mem[34'h10004] = 32'h0000_8001;
        pte_mem[34'h2000C] = 32'h048D_144B;
        exp_addr_q.push_back(34'h10004);
        exp_addr_q.push_back(34'h2000C);
        exp_q.push_back(mk_done(20'h00403, 22'h12345, 8'h4B, 1'b0));
        run_miss(32'h0040_3ABC, 6, 0, '0);

        // Superpage walk.
        pte_mem.delete();
        pte_mem[34'h10004] = 32'h0010_0049;
        exp_addr_q.push_back(34'h10004);
        exp_q.push_back(mk_done(20'h00403, 22'h00403, 8'h49, 1'b1));
        run_miss(32'h0040_3ABC, 4, 0, '0);

        // Fault cases at both levels.
        for (int i = 0; i < 6; i++) begin
            pte_mem.delete();
            pte_mem[34'h10004] = F_L1[i];
            pte_mem[34'h2000C] = F_L0[i];
            exp_addr_q.push_back(34'h10004);
            if (F_L1[i] == 32'h0000_8001) exp_addr_q.push_back(34'h2000C);
            exp_q.push_back(mk_fault());
            run_miss(32'h0040_3ABC, (F_L1[i] == 32'h0000_8001) ? 6 : 4, 0, '0);
        end

        // Translation off: miss is ignored.
        satpMode = 0;
        @(negedge clk);
        missValid = 1'b1;
        missVaddr = 32'h0040_3ABC;
        repeat (2) @(posedge clk);
        #1;
        check("satp_off_busy", busy, 1'b0);
        missValid = 1'b0;
        satpMode = 1;

        // Flush in L0_WAIT with slow response: drain, no pulse.
        pte_mem.delete();
        pte_mem[34'h10004] = 32'h0000_8001;
        pte_mem[34'h2000C] = 32'h048D_144B;
        delay_mem[34'h2000C] = 3;
        exp_addr_q.push_back(34'h10004);
        exp_addr_q.push_back(34'h2000C);
        @(negedge clk);
        missValid = 1'b1;
        @(posedge clk); #1;
        missValid = 1'b0;
        wait_state(S_L0_WAIT, "reach_l0_wait");
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("drain_state", dbgState, S_DRAIN);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_cycles", n, 3);
        check("drain_pulses", {done, fault, refillEnable}, 3'b000);
        delay_mem.delete();

        // Next miss after the drain is serviced.
        pte_mem[34'h10004] = 32'h0010_0049;
        exp_addr_q.push_back(34'h10004);
        exp_q.push_back(mk_done(20'h00403, 22'h00403, 8'h49, 1'b1));
        run_miss(32'h0040_3ABC, 4, 0, '0);

        // Grant withheld for 5 cycles: request must hold.
        grant_delay = 5;
        exp_addr_q.push_back(34'h10004);
        exp_q.push_back(mk_done(20'h00403, 22'h00403, 8'h49, 1'b1));
        run_miss(32'h0040_3ABC, -1, 5, 34'h10004);
        grant_delay = 0;

        // Reset in L1_WAIT.
        delay_mem[34'h10004] = 5;
        exp_addr_q.push_back(34'h10004);
        @(negedge clk);
        missValid = 1'b1;
        @(posedge clk); #1;
        missValid = 1'b0;
        wait_state(S_L1_WAIT, "reach_l1_wait");
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_mem", {mem_if.memReq, mem_if.memAddr}, 35'h0);
        check("midrst_refill", {refillEnable, refillVpn, refillPpn, refillFlags, refillSuperpage}, 52'h0);
        check("midrst_outs", {done, fault, busy}, 3'b000);
        rst = 1'b0;
        delay_mem.delete();
        repeat (8) @(posedge clk);
        #1;
        check("midrst_quiet", {busy, done, fault}, 3'b000);

        // Random walks with random memory timing.
        for (int i = 0; i < 10; i++) begin
            pte_mem.delete();
            va          = $urandom;
            root        = ppn_t'($urandom_range(0, 32'h3FFFFF));
            node        = root ^ 22'h1;
            sp          = 1'($urandom_range(0, 1));
            grant_delay = $urandom_range(0, 2);
            satpPpn     = root;
            delay_mem[l1_addr(root, va)] = $urandom_range(0, 3);
            exp_addr_q.push_back(l1_addr(root, va));
            if (sp) begin
                leaf = {12'($urandom_range(0, 4095)), 10'b0};
                flg  = 8'h49 | ($urandom_range(0, 1) ? 8'h02 : 8'h00);
                pte_mem[l1_addr(root, va)] = {leaf, 2'b00, flg};
                exp_q.push_back(mk_done(va[31:12], {leaf[21:10], va[21:12]}, flg, 1'b1));
            end else begin
                leaf = ppn_t'($urandom_range(0, 32'h3FFFFF));
                flg  = 8'h4B | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
                pte_mem[l1_addr(root, va)] = {node, 2'b00, 8'h01};
                pte_mem[l0_addr(node, va)] = {leaf, 2'b00, flg};
                delay_mem[l0_addr(node, va)] = $urandom_range(0, 3);
                exp_addr_q.push_back(l0_addr(node, va));
                exp_q.push_back(mk_done(va[31:12], leaf, flg, 1'b0));
            end
            run_miss(va, -1, 0, '0);
            delay_mem.delete();
        end
        grant_delay = 0;

        repeat (4) @(posedge clk);
        #1;
        check("results_left", exp_q.size(), 0);
        check("addrs_left", exp_addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d miscompares so far expected completion", n_err);
        $fatal(1, "watchdog");
    end

endmodule
